// File: rtl/sensors_acquisition.sv
// Scans five serial greenhouse sensors and publishes one packed 40-bit reading frame atomically.
// Optional build macro SENSOR_RANGE_CHECK_EN rejects readings outside [TEMP_MIN, TEMP_MAX].
module sensors_acquisition #(
  parameter int unsigned BIT_DIV  = 4,
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [7:0]  TEMP_MIN = 8'd0,
  parameter logic [7:0]  TEMP_MAX = 8'd60
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [4:0]  sensor_sd_i,
  output logic [4:0]  sensor_req_o,
  output logic [39:0] sensors_data_o,
  output logic [4:0]  sensors_en_o,
  output logic [4:0]  sensor_err_o,
  output logic        frame_valid_o,
  output logic        busy_o,
  output logic [2:0]  state_dbg_o
);

  // Handshake: start_i is a level request accepted only in IDLE; frame_valid_o is a
  // one-cycle strobe with no back-pressure, and the frame stays on the outputs until the next one.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_DATA    = 3'd3,
    S_STOP    = 3'd4,
    S_PUBLISH = 3'd5
  } state_t;

  state_t      state, next_state;
  logic [2:0]  k;
  logic [11:0] cnt;
  logic [3:0]  bit_idx;
  logic [7:0]  rx;
  logic [39:0] sh_data, out_data;
  logic [4:0]  sh_en, sh_err, out_en, out_err;
  logic        sd_k;
  logic [11:0] sample_at;
  logic        in_range;
  logic        resolve;
  logic [7:0]  res_byte;
  logic        res_en, res_err;

  assign sd_k = sensor_sd_i[k];
  // cnt is 0 at the start-bit cycle, so bit n (and the stop bit at n=8) sits mid-period here.
  assign sample_at = 12'((32'(bit_idx) + 32'd1) * BIT_DIV + BIT_DIV / 2);

`ifdef SENSOR_RANGE_CHECK_EN
  assign in_range = (rx >= TEMP_MIN) && (rx <= TEMP_MAX);
`else
  logic unused_range_params;
  assign unused_range_params = ^{TEMP_MIN, TEMP_MAX};
  assign in_range = 1'b1;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state   = state;
    sensor_req_o = 5'b00000;
    resolve      = 1'b0;
    res_byte     = 8'h00;
    res_en       = 1'b0;
    res_err      = 1'b0;
    case (state)
      S_IDLE: if (start_i) next_state = S_REQ;
      S_REQ: begin
        sensor_req_o = 5'(5'b00001 << k);
        next_state   = S_WAIT;
      end
      S_WAIT: begin
        if (sd_k) next_state = S_DATA;
        else if (cnt == 12'(TIMEOUT - 1)) resolve = 1'b1;
      end
      S_DATA: if (cnt == sample_at && bit_idx == 4'd7) next_state = S_STOP;
      S_STOP: begin
        if (cnt == sample_at) begin
          resolve = 1'b1;
          if (!sd_k && in_range) begin
            res_byte = rx;
            res_en   = 1'b1;
          end else begin
            res_err  = 1'b1;
          end
        end
      end
      S_PUBLISH: next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
    if (resolve) next_state = (k == 3'd4) ? S_PUBLISH : S_REQ;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      k        <= 3'd0;
      cnt      <= 12'd0;
      bit_idx  <= 4'd0;
      rx       <= 8'h00;
      sh_data  <= 40'h0;
      sh_en    <= 5'b0;
      sh_err   <= 5'b0;
      out_data <= 40'h0;
      out_en   <= 5'b0;
      out_err  <= 5'b0;
    end else begin
      case (state)
        S_REQ: cnt <= 12'd0;
        S_WAIT: begin
          cnt     <= sd_k ? 12'd1 : cnt + 12'd1;
          bit_idx <= 4'd0;
        end
        S_DATA: begin
          cnt <= cnt + 12'd1;
          if (cnt == sample_at) begin
            rx      <= {rx[6:0], sd_k};
            bit_idx <= bit_idx + 4'd1;
          end
        end
        S_STOP: cnt <= cnt + 12'd1;
        S_PUBLISH: begin
          out_data <= sh_data;
          out_en   <= sh_en;
          out_err  <= sh_err;
          k        <= 3'd0;
        end
        default: ;
      endcase
      if (resolve) begin
        sh_data[{k, 3'b000} +: 8] <= res_byte;
        sh_en[k]                  <= res_en;
        sh_err[k]                 <= res_err;
        k                         <= k + 3'd1;
      end
    end
  end

  // The shadow frame is shown directly during PUBLISH so the strobe and the new data coincide.
  assign sensors_data_o = (state == S_PUBLISH) ? sh_data : out_data;
  assign sensors_en_o   = (state == S_PUBLISH) ? sh_en   : out_en;
  assign sensor_err_o   = (state == S_PUBLISH) ? sh_err  : out_err;
  assign frame_valid_o  = (state == S_PUBLISH);
  assign busy_o         = (state != S_IDLE) && (state != S_PUBLISH);
  assign state_dbg_o    = state;

endmodule

// File: tb/tb_sensors_acquisition.sv
// Directed bench for sensors_acquisition: scripted sensor frames, cycle-exact strobe and frame checks.
module tb_sensors_acquisition;

  localparam int BIT_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sd_line [5];
  logic [4:0]  sensor_sd;
  logic [4:0]  sensor_req;
  logic [39:0] sensors_data;
  logic [4:0]  sensors_en;
  logic [4:0]  sensor_err;
  logic        frame_valid;
  logic        busy;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int req_log[$];
  logic [39:0] cap_data, cap_data_next;
  logic [4:0]  cap_en, cap_err;
  logic        cap_busy, cap_fv_next;

  assign sensor_sd = {sd_line[4], sd_line[3], sd_line[2], sd_line[1], sd_line[0]};

  sensors_acquisition dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .sensor_sd_i    (sensor_sd),
    .sensor_req_o   (sensor_req),
    .sensors_data_o (sensors_data),
    .sensors_en_o   (sensors_en),
    .sensor_err_o   (sensor_err),
    .frame_valid_o  (frame_valid),
    .busy_o         (busy),
    .state_dbg_o    (state_dbg)
  );

  always #5 clk = ~clk;

  // Sensor model: answer 'delay' WAIT cycles late with start bit, 8 bits MSB first, stop bit.
  task automatic drive_sensor(input int k, input int delay, input logic [7:0] val, input logic stop_bit);
    logic [9:0] frame;
    int waited;
    frame  = {1'b1, val, stop_bit};
    waited = 0;
    while (sensor_req[k] !== 1'b1 && waited < 600) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 600) begin
      n_checks++;
      n_fail++;
      $display("FAIL sensor%0d_req: no request seen within 600 cycles", k);
    end else begin
      repeat (delay + 1) @(negedge clk);
      for (int i = 9; i >= 0; i--) begin
        sd_line[k] = frame[i];
        repeat (BIT_DIV) @(negedge clk);
      end
      sd_line[k] = 1'b0;
    end
  endtask

  // Pulses start at cycle t0 (the current one) and returns the strobe offset from t0.
  task automatic run_scan(input logic hold_start, input logic [39:0] prev_data,
                          output int fv_cyc, output int hold_errs);
    req_log.delete();
    hold_errs = 0;
    fv_cyc    = -1;
    start     = 1'b1;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      if (sensor_req !== 5'b0) req_log.push_back(c * 32 + int'(sensor_req));
      if (frame_valid === 1'b1) begin
        fv_cyc   = c;
        cap_data = sensors_data;
        cap_en   = sensors_en;
        cap_err  = sensor_err;
        cap_busy = busy;
        break;
      end
      if (sensors_data !== prev_data) hold_errs++;
      @(negedge clk);
    end
    @(negedge clk);
    cap_fv_next   = frame_valid;
    cap_data_next = sensors_data;
  endtask

  task automatic test_reset;
    int req_seen;
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) sd_line[i] = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (sensors_data !== 40'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", sensors_data); end
    n_checks++;
    if ({sensors_en, sensor_err} !== 10'h0) begin n_fail++; $display("FAIL reset_en_err: got %b/%b want 0", sensors_en, sensor_err); end
    n_checks++;
    if ({busy, frame_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_fv: got %b want 00", {busy, frame_valid}); end
    n_checks++;
    if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    rst = 1'b0;
    req_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (sensor_req !== 5'b0 || busy !== 1'b0) req_seen++;
    end
    n_checks++;
    if (req_seen !== 0) begin n_fail++; $display("FAIL idle_quiet: got %0d active cycles want 0", req_seen); end
  endtask

  task automatic test_silent;
    int fv, herr;
    int exp_log[5];
    exp_log = '{1 * 32 + 1, 18 * 32 + 2, 35 * 32 + 4, 52 * 32 + 8, 69 * 32 + 16};
    run_scan(1'b0, 40'h0, fv, herr);
    n_checks++;
    if (fv !== 86) begin n_fail++; $display("FAIL silent_fv_cycle: got %0d want 86", fv); end
    n_checks++;
    if (req_log.size() !== 5) begin n_fail++; $display("FAIL silent_req_count: got %0d want 5", req_log.size()); end
    for (int i = 0; i < 5 && i < req_log.size(); i++) begin
      n_checks++;
      if (req_log[i] !== exp_log[i])
        begin n_fail++; $display("FAIL silent_req%0d: got cyc %0d req %b want cyc %0d req %b", i,
          req_log[i] / 32, 5'(req_log[i] % 32), exp_log[i] / 32, 5'(exp_log[i] % 32)); end
    end
    n_checks++;
    if ({cap_data, cap_en, cap_err} !== 50'h0) begin n_fail++; $display("FAIL silent_frame: got %h %b %b want 0", cap_data, cap_en, cap_err); end
  endtask

  task automatic test_all_present;
    int fv, herr;
    fork
      drive_sensor(0, 0, 8'd20, 1'b0);
      drive_sensor(1, 0, 8'd21, 1'b0);
      drive_sensor(2, 0, 8'd22, 1'b0);
      drive_sensor(3, 0, 8'd23, 1'b0);
      drive_sensor(4, 0, 8'd24, 1'b0);
      run_scan(1'b0, 40'h0, fv, herr);
    join
    n_checks++;
    if (fv !== 201) begin n_fail++; $display("FAIL present_fv_cycle: got %0d want 201", fv); end
    n_checks++;
    if (cap_data !== 40'h1817161514) begin n_fail++; $display("FAIL present_data: got %h want 1817161514", cap_data); end
    n_checks++;
    if ({cap_en, cap_err} !== 10'b11111_00000) begin n_fail++; $display("FAIL present_en_err: got %b/%b want 11111/00000", cap_en, cap_err); end
    n_checks++;
    if (cap_busy !== 1'b0) begin n_fail++; $display("FAIL present_busy_at_fv: got %b want 0", cap_busy); end
    n_checks++;
    if (cap_fv_next !== 1'b0 || cap_data_next !== 40'h1817161514)
      begin n_fail++; $display("FAIL present_after_fv: got fv %b data %h want 0 1817161514", cap_fv_next, cap_data_next); end
    n_checks++;
    if (herr !== 0) begin n_fail++; $display("FAIL present_hold: got %0d changed cycles want 0", herr); end
  endtask

  task automatic test_mixed;
    int fv, herr;
    fork
      drive_sensor(0, 0, 8'd25, 1'b0);
      drive_sensor(1, 2, 8'd25, 1'b0);
      drive_sensor(2, 0, 8'd25, 1'b1);
      drive_sensor(3, 0, 8'd25, 1'b0);
      run_scan(1'b0, 40'h1817161514, fv, herr);
    join
    n_checks++;
    if (fv !== 180) begin n_fail++; $display("FAIL mixed_fv_cycle: got %0d want 180", fv); end
    n_checks++;
    if (cap_data !== 40'h0019001919) begin n_fail++; $display("FAIL mixed_data: got %h want 0019001919", cap_data); end
    n_checks++;
    if (cap_en !== 5'b01011) begin n_fail++; $display("FAIL mixed_en: got %b want 01011", cap_en); end
    n_checks++;
    if (cap_err !== 5'b00100) begin n_fail++; $display("FAIL mixed_err: got %b want 00100", cap_err); end
    n_checks++;
    if (herr !== 0) begin n_fail++; $display("FAIL mixed_hold: got %0d changed cycles want 0", herr); end
  endtask

  task automatic test_range;
    int fv, herr;
    logic [39:0] exp_data;
    logic [4:0]  exp_en, exp_err;
`ifdef SENSOR_RANGE_CHECK_EN
    exp_data = 40'h013B003C00;
    exp_en   = 5'b11110;
    exp_err  = 5'b00001;
`else
    exp_data = 40'h013B003C3D;
    exp_en   = 5'b11111;
    exp_err  = 5'b00000;
`endif
    fork
      drive_sensor(0, 0, 8'd61, 1'b0);
      drive_sensor(1, 0, 8'd60, 1'b0);
      drive_sensor(2, 0, 8'd0, 1'b0);
      drive_sensor(3, 15, 8'd59, 1'b0);
      drive_sensor(4, 0, 8'd1, 1'b0);
      run_scan(1'b0, 40'h0019001919, fv, herr);
    join
    n_checks++;
    if (fv !== 216) begin n_fail++; $display("FAIL range_fv_cycle: got %0d want 216", fv); end
    n_checks++;
    if (cap_data !== exp_data) begin n_fail++; $display("FAIL range_data: got %h want %h", cap_data, exp_data); end
    n_checks++;
    if ({cap_en, cap_err} !== {exp_en, exp_err}) begin n_fail++; $display("FAIL range_en_err: got %b/%b want %b/%b", cap_en, cap_err, exp_en, exp_err); end
  endtask

  task automatic test_reset_mid_scan;
    int fv, herr, stray;
    fork
      drive_sensor(0, 0, 8'd40, 1'b0);
      drive_sensor(1, 0, 8'd41, 1'b0);
      drive_sensor(2, 0, 8'd42, 1'b0);
      drive_sensor(3, 0, 8'd43, 1'b0);
      begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (129) @(negedge clk);
        n_checks++;
        if (state_dbg !== 3'd3) begin n_fail++; $display("FAIL midscan_in_data: got state %0d want 3", state_dbg); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({sensors_data, sensors_en, sensor_err} !== 50'h0)
          begin n_fail++; $display("FAIL midscan_cleared: got %h %b %b want 0", sensors_data, sensors_en, sensor_err); end
        n_checks++;
        if ({busy, frame_valid, state_dbg} !== 5'b0) begin n_fail++; $display("FAIL midscan_idle: got busy %b fv %b st %0d want 0", busy, frame_valid, state_dbg); end
        stray = 0;
        repeat (250) begin
          @(negedge clk);
          if (frame_valid !== 1'b0 || sensor_req !== 5'b0) stray++;
        end
        n_checks++;
        if (stray !== 0) begin n_fail++; $display("FAIL midscan_no_frame: got %0d active cycles want 0", stray); end
      end
    join
    fork
      drive_sensor(0, 0, 8'd30, 1'b0);
      drive_sensor(1, 0, 8'd31, 1'b0);
      drive_sensor(2, 0, 8'd32, 1'b0);
      drive_sensor(3, 0, 8'd33, 1'b0);
      drive_sensor(4, 0, 8'd34, 1'b0);
      run_scan(1'b0, 40'h0, fv, herr);
    join
    n_checks++;
    if (fv !== 201) begin n_fail++; $display("FAIL fresh_fv_cycle: got %0d want 201", fv); end
    n_checks++;
    if ({cap_data, cap_en, cap_err} !== {40'h2221201F1E, 5'b11111, 5'b00000})
      begin n_fail++; $display("FAIL fresh_frame: got %h %b %b want 2221201f1e 11111 00000", cap_data, cap_en, cap_err); end
  endtask

  task automatic test_back_to_back;
    int fv, herr, c;
    run_scan(1'b1, 40'h2221201F1E, fv, herr);
    n_checks++;
    if (fv !== 86) begin n_fail++; $display("FAIL b2b_first_fv: got %0d want 86", fv); end
    n_checks++;
    if (state_dbg !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap: got state %0d busy %b want 0 0", state_dbg, busy); end
    @(negedge clk);
    n_checks++;
    if (sensor_req !== 5'b00001 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: got req %b busy %b want 00001 1", sensor_req, busy); end
    start = 1'b0;
    c = 88;
    while (frame_valid !== 1'b1 && c < 700) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (c !== 173) begin n_fail++; $display("FAIL b2b_second_fv: got %0d want 173", c); end
    n_checks++;
    if ({sensors_data, sensors_en, sensor_err} !== 50'h0)
      begin n_fail++; $display("FAIL b2b_second_frame: got %h %b %b want 0", sensors_data, sensors_en, sensor_err); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_silent();
    test_all_present();
    test_mixed();
    test_range();
    test_reset_mid_scan();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
